// File: rtl/vga_frame_scanner.sv
// ---------------------------------------------------------------------------
// vga_frame_scanner
//
// Raster timing generator and pixel sink for the VGA output. The scanner
// issues pixelX/pixelY to the drawing objects, samples the registered
// RRRGGGBB colour from the object priority mux, and drives the VGA pins.
// hSync, vSync and blankN are delayed so that they line up with that pixel.
//
// Ports
//   clk           in   system clock
//   resetN        in   asynchronous active-low reset
//   pixelEn       in   one-clk pixel tick strobe (period >= 2 clk)
//   RGBIn[7:0]    in   pixel colour from object mux {R[2:0],G[2:0],B[1:0]}
//   pixelX[10:0]  out  horizontal scan position, 0..H_TOTAL-1
//   pixelY[10:0]  out  vertical scan position, 0..V_TOTAL-1
//   startOfFrame  out  high during the tick cycle that wraps the scan to (0,0)
//   hSync, vSync  out  active-low syncs, aligned with the colour outputs
//   blankN        out  1 = active video on red/green/blue
//   red/green/blue[3:0] out  4:4:4 expanded colour, 0 while blanked
// ---------------------------------------------------------------------------
module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_LAT = 1
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        pixelEn,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT_END   = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT_END   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START    = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END      = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Idle timing triple {active, hs_n, vs_n}: blanked, syncs inactive.
    localparam logic [2:0]  TMG_IDLE    = 3'b011;

    // 3-bit colour field to 4 bits: replicate the MSB into the LSB.
    function automatic logic [3:0] expand3(input logic [2:0] c);
        return {c, c[2]};
    endfunction

    // 2-bit colour field to 4 bits: repeat the field.
    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

    logic       x_wrap;
    logic       y_wrap;
    logic       active_p0;
    logic       hs_n_p0;
    logic       vs_n_p0;
    logic [2:0] tmg_p1 [PIPE_LAT];
    logic [2:0] tmg_out;

    assign x_wrap = (pixelX == X_LAST);
    assign y_wrap = (pixelY == Y_LAST);

    // Combinational on pixelEn so it is only high in the wrapping tick cycle.
    assign startOfFrame = pixelEn & x_wrap & y_wrap;

    // ---- stage p0: scan counters and undelayed timing decode ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pixelX <= '0;
            pixelY <= '0;
        end else if (pixelEn) begin
            if (x_wrap) begin
                pixelX <= '0;
                pixelY <= y_wrap ? 11'd0 : pixelY + 11'd1;
            end else begin
                pixelX <= pixelX + 11'd1;
            end
        end
    end

    assign active_p0 = (pixelX < X_ACT_END) && (pixelY < Y_ACT_END);
    assign hs_n_p0   = !((pixelX >= HS_START) && (pixelX < HS_END));
    assign vs_n_p0   = !((pixelY >= VS_START) && (pixelY < VS_END));

    // ---- stage p1: PIPE_LAT-deep timing delay, matching the mux latency ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tmg_p1[i] <= TMG_IDLE;
            end
        end else if (pixelEn) begin
            tmg_p1[0] <= {active_p0, hs_n_p0, vs_n_p0};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tmg_p1[i] <= tmg_p1[i-1];
            end
        end
    end

    assign tmg_out = tmg_p1[PIPE_LAT-1];

    // ---- stage p2: VGA pin registers ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blankN <= 1'b0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (pixelEn) begin
            blankN <= tmg_out[2];
            hSync  <= tmg_out[1];
            vSync  <= tmg_out[0];
            if (tmg_out[2]) begin
                red   <= expand3(RGBIn[7:5]);
                green <= expand3(RGBIn[4:2]);
                blue  <= expand2(RGBIn[1:0]);
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
module tb_vga_frame_scanner;

    // Reduced raster so several full frames fit in a short run.
    localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
    localparam int PL = 2;
    localparam int HT = HA + HFP + HS + HBP;   // 28
    localparam int VT = VA + VFP + VS + VBP;   // 11
    localparam int FRAME = HT * VT;            // 308 ticks

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        pixelEn = 1'b0;
    logic [7:0]  RGBIn = 8'h00;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, hSync, vSync, blankN;
    logic [3:0]  red, green, blue;

    vga_frame_scanner #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .resetN(resetN), .pixelEn(pixelEn), .RGBIn(RGBIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .hSync(hSync), .vSync(vSync), .blankN(blankN),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    // Reference model state: number of ticks since reset plus expected pins.
    int n = 0;
    int exp_blank = 0, exp_hs = 1, exp_vs = 1;
    int exp_r = 0, exp_g = 0, exp_b = 0;

    // Measurements taken from the DUT pins.
    int sof_ticks[$];
    int hs_runs[$];
    int vs_runs[$];
    int hs_fall_ticks[$];
    int hs_low = 0, vs_low = 0, prev_hs = 1;

    typedef struct {
        logic [7:0] rgb;
        int r, g, b;
    } colour_vec_t;
    colour_vec_t cvec[6];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, expv, n);
    endtask

    function automatic int cx(input int k); return k % HT; endfunction
    function automatic int cy(input int k); return (k / HT) % VT; endfunction

    // Colour expansion in arithmetic form: 3-bit v -> 2v + v/4, 2-bit v -> 5v.
    function automatic int ex3(input int v); return 2 * v + v / 4; endfunction
    function automatic int ex2(input int v); return 5 * v; endfunction

    task automatic check_pins();
        check("pixelX", int'(pixelX), cx(n));
        check("pixelY", int'(pixelY), cy(n));
        check("blankN", int'(blankN), exp_blank);
        check("hSync",  int'(hSync),  exp_hs);
        check("vSync",  int'(vSync),  exp_vs);
        check("red",    int'(red),    exp_r);
        check("green",  int'(green),  exp_g);
        check("blue",   int'(blue),   exp_b);
    endtask

    task automatic model_reset();
        n = 0;
        exp_blank = 0; exp_hs = 1; exp_vs = 1;
        exp_r = 0; exp_g = 0; exp_b = 0;
        hs_low = 0; vs_low = 0; prev_hs = 1;
    endtask

    // One pixel tick: pixelEn high for one clk, then one idle clk.
    task automatic do_tick(input logic [7:0] rgb);
        int k, x, y;
        @(negedge clk);
        pixelEn = 1'b1;
        RGBIn = rgb;
        #1;
        check("startOfFrame", int'(startOfFrame),
              (cx(n) == HT - 1 && cy(n) == VT - 1) ? 1 : 0);
        if (startOfFrame) sof_ticks.push_back(n);
        @(negedge clk);
        pixelEn = 1'b0;
        n++;
        // Pins now show the coordinate issued PL+1 ticks before this one.
        k = n - 1 - PL;
        if (k < 0) begin
            exp_blank = 0; exp_hs = 1; exp_vs = 1;
        end else begin
            x = cx(k);
            y = cy(k);
            exp_blank = (x < HA && y < VA) ? 1 : 0;
            exp_hs = (x >= HA + HFP && x < HA + HFP + HS) ? 0 : 1;
            exp_vs = (y >= VA + VFP && y < VA + VFP + VS) ? 0 : 1;
        end
        if (exp_blank == 1) begin
            exp_r = ex3(int'(rgb) / 32);
            exp_g = ex3((int'(rgb) / 4) % 8);
            exp_b = ex2(int'(rgb) % 4);
        end else begin
            exp_r = 0; exp_g = 0; exp_b = 0;
        end
        check_pins();
        // Sync pulse measurements
        if (hSync == 1'b0) begin
            if (prev_hs == 1) hs_fall_ticks.push_back(n);
            hs_low++;
        end else if (hs_low > 0) begin
            hs_runs.push_back(hs_low);
            hs_low = 0;
        end
        prev_hs = int'(hSync);
        if (vSync == 1'b0) vs_low++;
        else if (vs_low > 0) begin
            vs_runs.push_back(vs_low);
            vs_low = 0;
        end
    endtask

    initial begin
        logic [7:0] rgb;
        int guard;

        cvec[0] = '{8'hE0, 15, 0, 0};
        cvec[1] = '{8'h1D, 0, 15, 5};
        cvec[2] = '{8'hFF, 15, 15, 15};
        cvec[3] = '{8'h92, 9, 9, 10};
        cvec[4] = '{8'h6D, 6, 6, 5};
        cvec[5] = '{8'h00, 0, 0, 0};

        // Reset held while pixelEn keeps toggling
        resetN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); pixelEn = 1'b1; RGBIn = 8'hFF;
            #1 check("reset_sof", int'(startOfFrame), 0);
            @(negedge clk); pixelEn = 1'b0;
        end
        model_reset();
        check_pins();
        @(negedge clk);
        resetN = 1'b1;

        // Table-driven colour expansion on the first visible pixels
        for (int i = 0; i < PL + 3; i++) do_tick(8'($urandom));
        for (int i = 0; i < 6; i++) begin
            do_tick(cvec[i].rgb);
            check("tbl_red",   int'(red),   cvec[i].r);
            check("tbl_green", int'(green), cvec[i].g);
            check("tbl_blue",  int'(blue),  cvec[i].b);
        end

        // Randomized colour over three full frames
        for (int i = 0; i < 3 * FRAME; i++) do_tick(8'($urandom));

        check("sof_count", sof_ticks.size(), 3);
        if (sof_ticks.size() >= 1) check("first_sof_tick", sof_ticks[0], FRAME - 1);
        for (int i = 1; i < sof_ticks.size(); i++)
            check("frame_period", sof_ticks[i] - sof_ticks[i-1], FRAME);
        check("hs_runs_seen", (hs_runs.size() >= 10) ? 1 : 0, 1);
        for (int i = 0; i < hs_runs.size() && i < 5; i++)
            check("hsync_width", hs_runs[i], HS);
        for (int i = 0; i < hs_fall_ticks.size() && i < 5; i++)
            check("hsync_fall_pos", (hs_fall_ticks[i] - (PL + 1)) % HT, HA + HFP);
        for (int i = 1; i < hs_fall_ticks.size() && i < 5; i++)
            check("line_period", hs_fall_ticks[i] - hs_fall_ticks[i-1], HT);
        check("vs_runs_seen", (vs_runs.size() >= 2) ? 1 : 0, 1);
        for (int i = 0; i < vs_runs.size(); i++)
            check("vsync_width", vs_runs[i], VS * HT);

        // Hold mid-line: pixelEn low for 10 clk, RGBIn wiggling
        guard = 0;
        while (!(cx(n) == 8 && cy(n) == 2) && guard < FRAME) begin
            do_tick(8'($urandom));
            guard++;
        end
        check("reach_hold_point", guard < FRAME ? 1 : 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RGBIn = 8'($urandom);
            #1;
            check("hold_sof", int'(startOfFrame), 0);
            check_pins();
        end

        // Blanked region: full-white input must not reach the pins
        guard = 0;
        while (!(cx(n - PL) >= HA) && guard < HT) begin
            do_tick(8'($urandom));
            guard++;
        end
        do_tick(8'hFF);
        check("blank_red",    int'(red),    0);
        check("blank_green",  int'(green),  0);
        check("blank_blue",   int'(blue),   0);
        check("blank_blankN", int'(blankN), 0);

        // Mid-frame reset at (HA/2, VA/2)
        guard = 0;
        while (!(cx(n) == HA / 2 && cy(n) == VA / 2) && guard < FRAME) begin
            do_tick(8'($urandom));
            guard++;
        end
        check("reach_reset_point", guard < FRAME ? 1 : 0, 1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        model_reset();
        check_pins();
        for (int i = 0; i < 3; i++) @(negedge clk);
        check_pins();
        resetN = 1'b1;
        sof_ticks.delete();
        for (int i = 0; i < FRAME + 4; i++) do_tick(8'($urandom));
        check("post_reset_sof_count", sof_ticks.size(), 1);
        if (sof_ticks.size() >= 1) check("post_reset_sof_tick", sof_ticks[0], FRAME - 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
